// File: rtl/prim_ram_1p_initiator.sv
// prim_ram_1p_initiator: single-port RAM initiator with init sweep, host arbitration and read-valid tracking
module prim_ram_1p_initiator #(
  parameter int Width = 32,
  parameter int Depth = 128,
  parameter logic [Width-1:0] InitValue = '0,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_req_i,
  output logic             init_done_o,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic             write_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Width-1:0] wmask_i,
  output logic             rvalid_o,
  output logic [Width-1:0] rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);
  typedef enum logic {Init, Idle} state_e;
  localparam logic [Aw-1:0] Last = Aw'(Depth - 1);
  state_e state;
  logic [Aw-1:0] cnt;
  logic idle, rvalid_q;
  assign idle = state == Idle;
  assign gnt_o = idle & req_i & ~init_req_i;
  // RAM port is held quiet while reset is asserted, independent of the clock
  assign ram_req_o = ~rst_i & (~idle | gnt_o);
  assign ram_write_o = ram_req_o & (~idle | write_i);
  assign ram_addr_o = ~ram_req_o ? '0 : idle ? addr_i : cnt;
  assign ram_wdata_o = ~ram_req_o ? '0 : idle ? wdata_i : InitValue;
  assign ram_wmask_o = ~ram_req_o ? '0 : idle ? wmask_i : '1;
  assign rvalid_o = rvalid_q;
  assign rdata_o = rvalid_q ? ram_rdata_i : '0;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= Init;
      cnt <= '0;
      init_done_o <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= gnt_o & ~write_i;
      if (!idle) begin
        cnt <= cnt == Last ? '0 : cnt + 1'b1;
        if (cnt == Last) begin
          state <= Idle;
          init_done_o <= 1'b1;
        end
      end else if (init_req_i) begin
        state <= Init;
        cnt <= '0;
        init_done_o <= 1'b0;
      end
    end
  end
endmodule
